branch_resolver_bht: RTL and testbench

- Parametrised successor to the pipeline PC-source resolver.
- Keeps the same 5-way PC_src priority encoding.
- Replaces the fixed predictor with an indexed table of saturating counters.
- Tracks each prediction from ID through EX1 to EX2, detects mispredictions internally, and trains the table at EX2 resolution.

---
 rtl/branch_resolver_bht.sv | 121 ++++++++++++
 tb/tb_branch_resolver_bht.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolver_bht.sv
// PC-source resolver with an indexed table of saturating counters trained at EX2.
// Optional macro BR_GSHARE_EN XORs a non-speculative global history register into the index.
module branch_resolver_bht #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      ID_opcode,
  input  logic [11:0]      EX1_opcode,
  input  logic [11:0]      EX2_opcode,
  input  logic [PC_W-1:0]  ID_PC,
  input  logic             EX2_taken,
  input  logic             stall,
  output logic [2:0]       PC_src,
  output logic             predicted,
  output logic             predicted_to_EX,
  output logic             Wrong_prediction
);

  localparam logic [11:0] OP_BEQ  = 12'h001;
  localparam logic [11:0] OP_BNE  = 12'h002;
  localparam logic [11:0] OP_BLT  = 12'h003;
  localparam logic [11:0] OP_BGE  = 12'h004;
  localparam logic [11:0] OP_BLTU = 12'h005;
  localparam logic [11:0] OP_BGEU = 12'h006;
  localparam logic [11:0] OP_J    = 12'h007;
  localparam logic [11:0] OP_JAL  = 12'h008;
  localparam logic [11:0] OP_JR   = 12'h009;
  localparam logic [11:0] OP_HLT  = 12'h00A;

  localparam int              ENTRIES     = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

  function automatic logic is_cond(input logic [11:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
           (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (|c) ? c - CNT_W'(1) : c;
  endfunction

  logic [CNT_W-1:0] tbl_q [ENTRIES];

  logic             ex1_vld_q, ex1_pred_q, ex2_vld_q, ex2_pred_q;
  logic [IDX_W-1:0] ex1_idx_q, ex2_idx_q;
  logic             ex1_vld_d, ex2_vld_d;
  logic [CNT_W-1:0] cnt_upd_d;

  logic [IDX_W-1:0] id_idx;
  logic             id_vld, id_pred_raw, upd_en;

`ifdef BR_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  assign id_idx = ID_PC[IDX_W-1:0] ^ ghr_q;
`else
  assign id_idx = ID_PC[IDX_W-1:0];
`endif

  // ID stage: table lookup (pre-update value, no bypass from the EX2 write)
  assign id_vld      = is_cond(ID_opcode);
  assign id_pred_raw = tbl_q[id_idx][CNT_W-1];

  assign Wrong_prediction = ex2_vld_q & is_cond(EX2_opcode) & (EX2_taken != ex2_pred_q);
  assign predicted        = id_vld & id_pred_raw & ~Wrong_prediction;
  assign predicted_to_EX  = ex1_vld_q & ex1_pred_q;
  assign upd_en           = ~stall & ex2_vld_q & is_cond(EX2_opcode);

  always_comb begin
    ex1_vld_d = id_vld & ~Wrong_prediction;
    ex2_vld_d = ex1_vld_q & ~Wrong_prediction;
    cnt_upd_d = EX2_taken ? sat_inc(tbl_q[ex2_idx_q]) : sat_dec(tbl_q[ex2_idx_q]);
  end

  always_comb begin
    PC_src = 3'b000;
    if (Wrong_prediction)                                   PC_src = 3'b100;
    else if (ID_opcode == OP_HLT)                           PC_src = 3'b010;
    else if (EX1_opcode == OP_JR)                           PC_src = 3'b011;
    else if (predicted || ID_opcode == OP_J || ID_opcode == OP_JAL) PC_src = 3'b001;
  end

  // ID -> EX1 -> EX2 tracking control and EX2 training
  always_ff @(posedge clk) begin
    if (rst) begin
      ex1_vld_q  <= 1'b0;
      ex1_pred_q <= 1'b0;
      ex2_vld_q  <= 1'b0;
      ex2_pred_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= CNT_WEAK_NT;
    end else if (!stall) begin
      ex1_vld_q  <= ex1_vld_d;
      ex1_pred_q <= id_pred_raw;
      ex2_vld_q  <= ex2_vld_d;
      ex2_pred_q <= ex1_pred_q;
      if (upd_en) tbl_q[ex2_idx_q] <= cnt_upd_d;
    end
  end

  // Index payload carries no reset; it is only consumed when its valid bit is set
  always_ff @(posedge clk) begin
    if (!stall) begin
      ex1_idx_q <= id_idx;
      ex2_idx_q <= ex1_idx_q;
    end
  end

`ifdef BR_GSHARE_EN
  always_ff @(posedge clk) begin
    if (rst)         ghr_q <= '0;
    else if (upd_en) ghr_q <= {ghr_q[IDX_W-2:0], EX2_taken};
  end
`endif

endmodule

// File: tb/tb_branch_resolver_bht.sv
// Directed self-checking bench for branch_resolver_bht (default parameters).
module tb_branch_resolver_bht;
  localparam logic [11:0] NOP = 12'h000, BEQ = 12'h001, J = 12'h007, JAL = 12'h008;
  localparam logic [11:0] JR = 12'h009, HLT = 12'h00A;

  logic        clk = 1'b0;
  logic        rst, EX2_taken, stall;
  logic [11:0] ID_opcode, EX1_opcode, EX2_opcode;
  logic [31:0] ID_PC;
  logic [2:0]  PC_src;
  logic        predicted, predicted_to_EX, Wrong_prediction;
  int          total = 0, bad = 0;
  int          cnt;

  branch_resolver_bht dut (
    .clk(clk), .rst(rst), .ID_opcode(ID_opcode), .EX1_opcode(EX1_opcode),
    .EX2_opcode(EX2_opcode), .ID_PC(ID_PC), .EX2_taken(EX2_taken), .stall(stall),
    .PC_src(PC_src), .predicted(predicted), .predicted_to_EX(predicted_to_EX),
    .Wrong_prediction(Wrong_prediction)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; EX2_taken = 1'b0;
    ID_opcode = NOP; EX1_opcode = NOP; EX2_opcode = NOP; ID_PC = '0;
    step();
    rst = 1'b0; #1;
  endtask

  task automatic resolve(input int pc, input logic taken);
    ID_opcode = BEQ; ID_PC = pc; step();
    ID_opcode = NOP; ID_PC = '0; step();
    EX2_opcode = BEQ; EX2_taken = taken; step();
    EX2_opcode = NOP; EX2_taken = 1'b0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (Wrong_prediction !== 1'b0) begin bad++; $display("FAIL rst_wp got=%b exp=0", Wrong_prediction); end
    total++; if (predicted_to_EX !== 1'b0) begin bad++; $display("FAIL rst_pte got=%b exp=0", predicted_to_EX); end
    total++; if (PC_src !== 3'b000) begin bad++; $display("FAIL rst_pcsrc got=%b exp=000", PC_src); end
    cnt = dut.tbl_q[5];
    total++; if (cnt !== 1) begin bad++; $display("FAIL rst_cnt5 got=%0d exp=1", cnt); end
    ID_opcode = BEQ; ID_PC = 5; #1;
    total++; if (predicted !== 1'b0) begin bad++; $display("FAIL t1_pred got=%b exp=0", predicted); end
    total++; if (PC_src !== 3'b000) begin bad++; $display("FAIL t1_pcsrc got=%b exp=000", PC_src); end
    step(); ID_opcode = NOP; step();
    EX2_opcode = BEQ; EX2_taken = 1'b0; #1;
    total++; if (Wrong_prediction !== 1'b0) begin bad++; $display("FAIL t1_wp got=%b exp=0", Wrong_prediction); end
    step(); EX2_opcode = NOP;
    cnt = dut.tbl_q[5];
    total++; if (cnt !== 0) begin bad++; $display("FAIL t1_cnt5 got=%0d exp=0", cnt); end
  endtask

  task automatic test_train_and_mispredict();
    do_reset();
    ID_opcode = BEQ; ID_PC = 5; step(); ID_opcode = NOP; step();
    EX2_opcode = BEQ; EX2_taken = 1'b1; #1;
    total++; if (Wrong_prediction !== 1'b1) begin bad++; $display("FAIL t2_wp1 got=%b exp=1", Wrong_prediction); end
    step(); EX2_opcode = NOP; EX2_taken = 1'b0;
    resolve(5, 1'b1);
    cnt = dut.tbl_q[5];
    total++; if (cnt !== 3) begin bad++; $display("FAIL t2_cnt5 got=%0d exp=3", cnt); end
    ID_opcode = BEQ; ID_PC = 5; #1;
    total++; if (predicted !== 1'b1) begin bad++; $display("FAIL t2_pred got=%b exp=1", predicted); end
    total++; if (PC_src !== 3'b001) begin bad++; $display("FAIL t2_pcsrc got=%b exp=001", PC_src); end
    step();
    total++; if (predicted_to_EX !== 1'b1) begin bad++; $display("FAIL t2_pte got=%b exp=1", predicted_to_EX); end
    // younger predicted-taken branch follows; it must be squashed by the mispredict
    step(); ID_opcode = NOP;
    EX2_opcode = BEQ; EX2_taken = 1'b0; #1;
    total++; if (Wrong_prediction !== 1'b1) begin bad++; $display("FAIL t3_wp got=%b exp=1", Wrong_prediction); end
    total++; if (PC_src !== 3'b100) begin bad++; $display("FAIL t3_pcsrc got=%b exp=100", PC_src); end
    step();
    cnt = dut.tbl_q[5];
    total++; if (cnt !== 2) begin bad++; $display("FAIL t3_cnt5 got=%0d exp=2", cnt); end
    total++; if (Wrong_prediction !== 1'b0) begin bad++; $display("FAIL t3_squash_wp got=%b exp=0", Wrong_prediction); end
    total++; if (predicted_to_EX !== 1'b0) begin bad++; $display("FAIL t3_squash_pte got=%b exp=0", predicted_to_EX); end
    step(); EX2_opcode = NOP;
    cnt = dut.tbl_q[5];
    total++; if (cnt !== 2) begin bad++; $display("FAIL t3_noupd got=%0d exp=2", cnt); end
  endtask

  task automatic test_priority();
    ID_opcode = BEQ; ID_PC = 5; step(); ID_opcode = NOP; step();
    EX2_opcode = BEQ; EX2_taken = 1'b0; ID_opcode = HLT; EX1_opcode = JR; #1;
    total++; if (PC_src !== 3'b100) begin bad++; $display("FAIL pri_wp got=%b exp=100", PC_src); end
    EX2_taken = 1'b1; #1;
    total++; if (PC_src !== 3'b010) begin bad++; $display("FAIL pri_hlt got=%b exp=010", PC_src); end
    ID_opcode = NOP; #1;
    total++; if (PC_src !== 3'b011) begin bad++; $display("FAIL pri_jr got=%b exp=011", PC_src); end
    EX1_opcode = NOP; ID_opcode = J; #1;
    total++; if (PC_src !== 3'b001) begin bad++; $display("FAIL pri_j got=%b exp=001", PC_src); end
    ID_opcode = JAL; #1;
    total++; if (PC_src !== 3'b001) begin bad++; $display("FAIL pri_jal got=%b exp=001", PC_src); end
    step(); ID_opcode = NOP; EX2_opcode = NOP; EX2_taken = 1'b0; #1;
  endtask

  task automatic test_saturation_and_stall();
    do_reset();
    for (int i = 0; i < 5; i++) resolve(7, 1'b1);
    cnt = dut.tbl_q[7];
    total++; if (cnt !== 3) begin bad++; $display("FAIL sat_hi got=%0d exp=3", cnt); end
    for (int i = 0; i < 5; i++) resolve(7, 1'b0);
    cnt = dut.tbl_q[7];
    total++; if (cnt !== 0) begin bad++; $display("FAIL sat_lo got=%0d exp=0", cnt); end
    resolve(9, 1'b1); resolve(9, 1'b1);
    ID_opcode = BEQ; ID_PC = 7; step();
    ID_opcode = BEQ; ID_PC = 9; step();
    ID_opcode = NOP; ID_PC = '0;
    EX2_opcode = BEQ; EX2_taken = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      cnt = dut.tbl_q[7];
      total++; if (cnt !== 0) begin bad++; $display("FAIL stall_cnt c%0d got=%0d exp=0", i, cnt); end
      total++; if (Wrong_prediction !== 1'b1) begin bad++; $display("FAIL stall_wp c%0d got=%b exp=1", i, Wrong_prediction); end
      total++; if (predicted_to_EX !== 1'b1) begin bad++; $display("FAIL stall_pte c%0d got=%b exp=1", i, predicted_to_EX); end
    end
    stall = 1'b0; step();
    cnt = dut.tbl_q[7];
    total++; if (cnt !== 1) begin bad++; $display("FAIL stall_upd got=%0d exp=1", cnt); end
    total++; if (Wrong_prediction !== 1'b0) begin bad++; $display("FAIL stall_squash got=%b exp=0", Wrong_prediction); end
    step();
    cnt = dut.tbl_q[7];
    total++; if (cnt !== 1) begin bad++; $display("FAIL stall_once got=%0d exp=1", cnt); end
    EX2_opcode = NOP; EX2_taken = 1'b0;
  endtask

  task automatic test_reset_mid();
    ID_opcode = BEQ; ID_PC = 9; step(); ID_opcode = NOP; step();
    EX2_opcode = BEQ; EX2_taken = 1'b0; rst = 1'b1; step(); rst = 1'b0; #1;
    total++; if (Wrong_prediction !== 1'b0) begin bad++; $display("FAIL midrst_wp got=%b exp=0", Wrong_prediction); end
    cnt = dut.tbl_q[9];
    total++; if (cnt !== 1) begin bad++; $display("FAIL midrst_cnt got=%0d exp=1", cnt); end
    EX2_opcode = NOP;
  endtask

  task automatic test_aliasing();
    do_reset();
    resolve(5, 1'b1); resolve(5, 1'b1);
    ID_opcode = BEQ; ID_PC = 69; #1;
`ifdef BR_GSHARE_EN
    total++; if (predicted !== 1'b0) begin bad++; $display("FAIL alias_gshare got=%b exp=0", predicted); end
`else
    total++; if (predicted !== 1'b1) begin bad++; $display("FAIL alias_pred got=%b exp=1", predicted); end
`endif
    ID_opcode = NOP; #1;
  endtask

  initial begin
    test_reset();
    test_train_and_mispredict();
    test_priority();
    test_saturation_and_stall();
    test_reset_mid();
    test_aliasing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
